// File: rtl/alu_arbiter_if.sv
// Request/response/ALU signal bundle for alu_arbiter; the slave modport is the arbiter side.
// The master modport is the environment: both requesters, the response consumer and the ALU.
interface alu_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) ();
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic              rsp_id;

    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_control;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_id,
        input  rsp_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_id,
        output rsp_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one external combinational ALU between two requesters.
// Latency: accept at edge N, rsp_valid after edge N+1; one op in flight, accepts >= 3 cycles apart.
// Backpressure: both req readys stay low from accept until the response is taken. Stats: ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_arbiter_if.slave    bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              gnt;
    logic              xfer;
    logic [WIDTH-1:0]  a_q, b_q, result_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              zero_q, id_q, valid_q;

    // With both valid, the requester that did not win last time goes next.
    always_comb begin
        gnt = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            gnt = ~last_grant;
        else if (!bus.req0_valid)
            gnt = 1'b1;
    end

    // Readies are gated by rst_n so every output reads 0 while reset is held.
    assign bus.req0_ready = rst_n && (state == IDLE) && bus.req0_valid && !gnt;
    assign bus.req1_ready = rst_n && (state == IDLE) && bus.req1_valid &&  gnt;
    assign xfer = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            id_q       <= 1'b0;
            valid_q    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && xfer) begin
                a_q        <= gnt ? bus.req1_a    : bus.req0_a;
                b_q        <= gnt ? bus.req1_b    : bus.req0_b;
                ctrl_q     <= gnt ? bus.req1_ctrl : bus.req0_ctrl;
                id_q       <= gnt;
                last_grant <= gnt;
            end
            if (state == EXEC) begin
                result_q <= bus.alu_result;
                zero_q   <= bus.alu_zero;
                valid_q  <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready)
                valid_q <= 1'b0;
        end
    end

    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_control = ctrl_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_valid   = valid_q;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (state == IDLE && xfer) begin
            if (gnt)
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            else
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: randomized and directed requests, scoreboard of expected responses.
module tb_alu_arbiter;
    localparam int W = 32;
    localparam int C = 4;
`ifdef ALU_ARB_STATS_EN
    localparam int CW = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .CTRL_W(C)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [CW-1:0] gnt_cnt0, gnt_cnt1;
    alu_arbiter #(.WIDTH(W), .CTRL_W(C), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1));
`else
    alu_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // External ALU stand-in; unknown codes give XOR so they still produce checkable data.
    function automatic logic [W-1:0] alu_f(input logic [C-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_control, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (alu_f(bus.alu_control, bus.alu_a, bus.alu_b) == '0);

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         id;
    } exp_t;

    exp_t q[$];
    int   since_accept = -1;  // -1: nothing in flight; else negedges since the accept was predicted
    bit   last = 1'b1;
    int   cnt0 = 0, cnt1 = 0;

    // Reference model + monitor: predicts grants, latency and response contents.
    always @(negedge clk) begin
        bit   v0, v1, g, e0, e1;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            since_accept = -1;
            last = 1'b1;
            cnt0 = 0;
            cnt1 = 0;
        end else begin
`ifdef ALU_ARB_STATS_EN
            chk("gnt_cnt0", gnt_cnt0, cnt0 % 4);
            chk("gnt_cnt1", gnt_cnt1, cnt1 % 4);
`endif
            if (since_accept < 0) begin
                v0 = bus.req0_valid;
                v1 = bus.req1_valid;
                g  = (v0 && v1) ? !last : !v0;
                e0 = v0 && !g;
                e1 = v1 && g;
                chk("req0_ready_idle", bus.req0_ready, e0);
                chk("req1_ready_idle", bus.req1_ready, e1);
                chk("rsp_valid_idle", bus.rsp_valid, 0);
                if (e0 || e1) begin
                    e.id   = g;
                    e.res  = g ? alu_f(bus.req1_ctrl, bus.req1_a, bus.req1_b)
                               : alu_f(bus.req0_ctrl, bus.req0_a, bus.req0_b);
                    e.zero = (e.res == '0);
                    q.push_back(e);
                    last = g;
                    if (g) cnt1++; else cnt0++;
                    since_accept = 0;
                end
            end else begin
                since_accept++;
                chk("req0_ready_busy", bus.req0_ready, 0);
                chk("req1_ready_busy", bus.req1_ready, 0);
                if (since_accept == 1) begin
                    chk("rsp_valid_exec", bus.rsp_valid, 0);
                end else begin
                    chk("rsp_valid_resp", bus.rsp_valid, 1);
                    if (q.size() == 0) begin
                        chk("scoreboard_nonempty", 0, 1);
                        since_accept = -1;
                    end else begin
                        chk("rsp_result", bus.rsp_result, q[0].res);
                        chk("rsp_zero", bus.rsp_zero, q[0].zero);
                        chk("rsp_id", bus.rsp_id, q[0].id);
                        if (bus.rsp_ready) begin
                            void'(q.pop_front());
                            since_accept = -1;
                        end
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [C-1:0] c0,
                           input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [C-1:0] c1,
                           input bit rr);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1;
        bus.rsp_ready  = rr;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 0);
        chk({tag, "_rsp_zero"}, bus.rsp_zero, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_alu_a"}, bus.alu_a, 0);
        chk({tag, "_alu_b"}, bus.alu_b, 0);
        chk({tag, "_alu_control"}, bus.alu_control, 0);
        chk({tag, "_req0_ready"}, bus.req0_ready, 0);
        chk({tag, "_req1_ready"}, bus.req1_ready, 0);
    endtask

    // Waits (bounded) until requester 0 is accepted; leaves time just after that edge.
    task automatic wait_accept0(output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready) seen = 1;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit seen;
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all_zero("reset");
        cycles(2);
        #1 rst_n = 1'b1;

        // Single ADD from requester 0
        set_req(1, 5, 7, 4'b0010, 0, 0, 0, 0, 1);
        cycles(1);
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(5);

        // SUB to zero from requester 1
        set_req(0, 0, 0, 0, 1, 9, 9, 4'b0110, 1);
        cycles(1);
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(5);

        // Continuous contention: AND vs OR
        set_req(1, 32'hF0, 32'h3C, 4'b0000, 1, 32'hF0, 32'h3C, 4'b0001, 1);
        cycles(12);
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(4);

        // Backpressure with the other requester still pending
        set_req(1, 1, 2, 4'b0010, 0, 0, 0, 0, 0);
        cycles(1);
        set_req(0, 0, 0, 0, 1, 3, 4, 4'b0010, 0);
        cycles(7);
        bus.rsp_ready = 1'b1;
        cycles(6);
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(4);

        // Reset during EXEC, both requesting across reset
        set_req(1, 32'h11, 32'h22, 4'b0010, 1, 32'h33, 32'h44, 4'b0001, 1);
        wait_accept0(seen);
        chk("accept_before_reset", seen, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midop_reset");
        cycles(2);
        #1 rst_n = 1'b1;
        cycles(8);
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(4);

`ifdef ALU_ARB_STATS_EN
        rst_n = 1'b0;
        cycles(1);
        #1 rst_n = 1'b1;
        set_req(1, 2, 3, 4'b0010, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            wait_accept0(seen);
            chk("stats_accept", seen, 1);
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(4);
        chk("stats_wrap_cnt0", gnt_cnt0, 1);
        chk("stats_cnt1", gnt_cnt1, 0);
`endif

        // Randomized traffic, including unknown codes and equal operands
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] a0, b0, a1, b1;
            a0 = $urandom();
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom();
            a1 = $urandom();
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom();
            set_req($urandom_range(0, 1) == 1, a0, b0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) == 1, a1, b1, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0);
            cycles(1);
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycles(6);
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: requester 0 is the primary datapath and requester 1 is an auxiliary engine (address generation or debug).
- Round-robin grant with a valid/ready handshake on each request port and on the single response port.
- Drives the ALU operand and control inputs from registers and captures the ALU result and zero flag into a response register.
- Sits between the requesters and the ALU instance; the ALU itself is instantiated outside this block.

Parameters:
- WIDTH, 32, operand and result width.
- CTRL_W, 4, ALU control code width.
- CNT_W, 16, grant counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_ctrl  in  CTRL_W  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- rsp_id  out  1  requester that owns the response (0 or 1).
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_control  out  CTRL_W  registered control code to the ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset is asynchronous, active low, and applies in any state:
  - state goes to IDLE;
  - alu_a, alu_b, alu_control, rsp_result, rsp_zero, rsp_id, rsp_valid all go to 0;
  - last_grant goes to 1, so requester 0 wins the first contention;
  - an in-flight operation is discarded with no response.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant selection: if exactly one reqN_valid is high, that requester is granted. If both are high, the requester other than last_grant is granted.
  - reqN_ready is driven combinationally high only for the granted requester, and only while in IDLE. The transfer happens on valid && ready.
  - On a transfer: latch that requester's a, b and ctrl into alu_a, alu_b and alu_control; set rsp_id and last_grant to the granted index; go to EXEC.
  - With no valid request: stay in IDLE; both ready outputs stay 0.
- EXEC (one cycle):
  - The ALU settles combinationally on the registered operands.
  - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_valid = 1 and go to RESP.
- RESP:
  - rsp_valid, rsp_result, rsp_zero and rsp_id stay stable until rsp_ready is high at a clock edge.
  - On that edge, clear rsp_valid and go to IDLE.
  - Both reqN_ready outputs are 0 throughout EXEC and RESP.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid is high after edge N+1.
  - Minimum spacing between accepts is 3 cycles, with rsp_ready held high.
- rsp_ready arriving while rsp_valid is low has no effect.
- Requester inputs change only under the requester's control. The block samples them only on the accepting edge; later changes do not affect the in-flight operation.
- alu_a, alu_b and alu_control keep their last values in IDLE; they are not cleared after a response.
- No arithmetic is done in this block; all codes, including unknown ones, pass to the ALU unchanged.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, each CNT_W wide.
  - Each counter increments by 1 on every accepted transfer of its requester.
  - Counters wrap from 2^CNT_W-1 to 0.
  - Counters reset to 0 on rst_n.
- When not defined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Single ADD: req0 a=5, b=7, ctrl=0010 -> req0_ready high in IDLE; 2 cycles later rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0.
- Zero flag: req1 a=9, b=9, ctrl=0110 (SUB) -> rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention: both valid continuously after reset, req0 ctrl=0000 a=F0 b=3C, req1 ctrl=0001 a=F0 b=3C -> grants alternate 0,1,0,1; results alternate 30, FC.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> response held stable, both ready outputs 0, no new grant; rsp_ready high -> IDLE next cycle, then next grant.
- Reset mid-operation: assert rst_n low during EXEC -> all outputs 0 immediately (without waiting for a clock edge); after release, no stale response appears and requester 0 wins the next contention.
- Stats (ALU_ARB_STATS_EN, CNT_W=2): 5 requester-0 accepts -> gnt_cnt0 reads 1 (wrapped), gnt_cnt1 reads 0.
